// File: rtl/mac_seq.sv
// mac_seq: sequential multiply-accumulate unit.
//
// Multiplies two N-bit operands (signed or unsigned) with a radix-2
// shift-and-add loop that stops as soon as the remaining multiplier bits are
// all zero. The product is then added into an ACC_W-bit accumulator, and a
// sticky overflow flag is kept.
//
// Handshake (level based): the requester raises start and holds it until done
// is seen. start is sampled only in IDLE; data_a/data_b/sgn are captured on
// that same edge. done stays high in DONE while start stays high, and the
// FSM returns to IDLE on the first edge that sees start low. A start held high
// after done therefore never retriggers.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           operation request (level)
//   acc_clr         clear accumulator and ovf, honoured only in IDLE
//   sgn             1 = two's-complement operands, 0 = unsigned
//   data_a, data_b  multiplicand / multiplier
//   busy            high in MUL and ADD
//   done            high in DONE
//   prod            last product, 2N bits
//   acc             accumulator, ACC_W bits
//   ovf             sticky accumulate overflow
//   dbg_state_o     current FSM state (IDLE=0, MUL=1, ADD=2, DONE=3)
module mac_seq #(
  parameter int N     = 32,
  parameter int ACC_W = 2 * N + 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             acc_clr,
  input  logic             sgn,
  input  logic [N-1:0]     data_a,
  input  logic [N-1:0]     data_b,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   prod,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sgn_q, sgn_d;
  logic               neg_q, neg_d;
  logic [2*N-1:0]     ma_q, ma_d;
  logic [N-1:0]       mb_q, mb_d;
  logic [2*N-1:0]     pp_q, pp_d;
  logic [2*N-1:0]     prod_q, prod_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;

  // Operand magnitudes. -2^(N-1) negates to itself, which read as unsigned is
  // exactly 2^(N-1), so N bits are enough.
  logic [N-1:0]       mag_a, mag_b;
  assign mag_a = (sgn && data_a[N-1]) ? -data_a : data_a;
  assign mag_b = (sgn && data_b[N-1]) ? -data_b : data_b;

  // Signed product from the unsigned partial product.
  logic [2*N-1:0]     p;
  assign p = neg_q ? -pp_q : pp_q;

  // Product extended to accumulator width: sign-extended for signed ops.
  logic [ACC_W-1:0]   ext;
  always_comb begin
    ext            = {ACC_W{sgn_q & p[2*N-1]}};
    ext[2*N-1:0]   = p;
  end

  // One extra bit keeps the unsigned carry-out.
  logic [ACC_W:0]     sum;
  logic               ovf_add;
  assign sum = {1'b0, acc_q} + {1'b0, ext};
  assign ovf_add = sgn_q ? ((acc_q[ACC_W-1] == ext[ACC_W-1]) &&
                            (sum[ACC_W-1] != acc_q[ACC_W-1]))
                         : sum[ACC_W];

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    pp_d    = pp_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (acc_clr) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        if (start) begin
          sgn_d   = sgn;
          neg_d   = sgn & (data_a[N-1] ^ data_b[N-1]);
          ma_d    = {{N{1'b0}}, mag_a};
          mb_d    = mag_b;
          pp_d    = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (mb_q[0]) pp_d = pp_q + ma_q;
        ma_d = ma_q << 1;
        mb_d = mb_q >> 1;
        // Early exit: no set multiplier bits remain after this step.
        if ((mb_q >> 1) == '0) state_d = ADD;
      end
      ADD: begin
        prod_d  = p;
        acc_d   = sum[ACC_W-1:0];
        if (ovf_add) ovf_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      pp_q    <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      pp_q    <= pp_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q == MUL) || (state_q == ADD);
  assign done        = (state_q == DONE);
  assign prod        = prod_q;
  assign acc         = acc_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_seq.sv
// Testbench for mac_seq: two instances (N=8 with ACC_W=24 and ACC_W=16)
// share data inputs; start/acc_clr are steered to the selected instance and
// its outputs are muxed back for checking. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_mac_seq;

  logic        clk;
  logic        reset;
  logic        start, acc_clr, sgn;
  logic [7:0]  data_a, data_b;
  logic        sel;

  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [15:0] prod0, prod1;
  logic [23:0] acc0;
  logic [15:0] acc1;
  logic [1:0]  st0, st1;

  logic        busy_m, done_m, ovf_m;
  logic [15:0] prod_m;
  logic [23:0] acc_m;
  logic [1:0]  st_m;

  int checks   = 0;
  int failures = 0;

  mac_seq #(.N(8), .ACC_W(24)) u0 (
    .clk(clk), .reset(reset), .start(start & ~sel), .acc_clr(acc_clr & ~sel),
    .sgn(sgn), .data_a(data_a), .data_b(data_b),
    .busy(busy0), .done(done0), .prod(prod0), .acc(acc0), .ovf(ovf0),
    .dbg_state_o(st0)
  );

  mac_seq #(.N(8), .ACC_W(16)) u1 (
    .clk(clk), .reset(reset), .start(start & sel), .acc_clr(acc_clr & sel),
    .sgn(sgn), .data_a(data_a), .data_b(data_b),
    .busy(busy1), .done(done1), .prod(prod1), .acc(acc1), .ovf(ovf1),
    .dbg_state_o(st1)
  );

  assign busy_m = sel ? busy1 : busy0;
  assign done_m = sel ? done1 : done0;
  assign ovf_m  = sel ? ovf1  : ovf0;
  assign prod_m = sel ? prod1 : prod0;
  assign acc_m  = sel ? {8'h00, acc1} : acc0;
  assign st_m   = sel ? st1 : st0;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Run one operation on instance s, starting at a falling edge.
  task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic sg, input logic clr, input int k,
                       input logic [15:0] e_prod, input logic [23:0] e_acc,
                       input logic e_ovf, input int hold);
    int edges;
    int busy_n;
    sel     = s;
    data_a  = a;
    data_b  = b;
    sgn     = sg;
    acc_clr = clr;
    start   = 1'b1;
    edges   = 0;
    busy_n  = 0;
    while (!done_m && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      acc_clr = 1'b0;
      data_a  = 8'($urandom_range(255));
      data_b  = 8'($urandom_range(255));
      sgn     = 1'($urandom_range(1));
      if (busy_m) busy_n++;
    end
    check_eq("latency", edges, k + 2);
    check_eq("busy_cycles", busy_n, k + 1);
    check_eq("done", done_m, 1'b1);
    check_eq("prod", prod_m, e_prod);
    check_eq("acc", acc_m, e_acc);
    check_eq("ovf", ovf_m, e_ovf);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_done", done_m, 1'b1);
      check_eq("hold_acc", acc_m, e_acc);
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("drop_done", done_m, 1'b0);
    check_eq("drop_state", st_m, 2'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; acc_clr = 1'b0; sgn = 1'b0;
    data_a = 8'h00; data_b = 8'h00; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state, both instances.
    check_eq("rst_state0", st0, 2'd0);
    check_eq("rst_busy0", busy0, 1'b0);
    check_eq("rst_done0", done0, 1'b0);
    check_eq("rst_prod0", prod0, 16'h0);
    check_eq("rst_acc0", acc0, 24'h0);
    check_eq("rst_ovf0", ovf0, 1'b0);
    check_eq("rst_acc1", acc1, 16'h0);
    check_eq("rst_ovf1", ovf1, 1'b0);

    // Unsigned 0xFF*0xFF with clear.
    do_op(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 8, 16'hFE01, 24'h00FE01, 1'b0, 0);
    // Signed -128 * -128 from clear, then -3 * 5.
    do_op(1'b0, 8'h80, 8'h80, 1'b1, 1'b1, 8, 16'h4000, 24'h004000, 1'b0, 0);
    do_op(1'b0, 8'hFD, 8'h05, 1'b1, 1'b0, 3, 16'hFFF1, 24'h003FF1, 1'b0, 0);
    // Zero multiplier: shortest loop. Then 1 * -1.
    do_op(1'b0, 8'h05, 8'h00, 1'b1, 1'b1, 1, 16'h0000, 24'h000000, 1'b0, 0);
    do_op(1'b0, 8'h01, 8'hFF, 1'b1, 1'b0, 1, 16'hFFFF, 24'hFFFFFF, 1'b0, 0);
    // Unsigned 3*4 onto 0xFFFFFF carries out; start held 5 cycles past done.
    do_op(1'b0, 8'h03, 8'h04, 1'b0, 1'b0, 3, 16'h000C, 24'h00000B, 1'b1, 5);

    // Narrow accumulator: unsigned overflow is sticky.
    do_op(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 8, 16'hFE01, 24'h00FE01, 1'b0, 0);
    do_op(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 8, 16'hFE01, 24'h00FC02, 1'b1, 0);
    do_op(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 8, 16'hFE01, 24'h00FA03, 1'b1, 0);
    // acc_clr alone in IDLE.
    sel = 1'b1; acc_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_clr = 1'b0;
    check_eq("clr_acc1", acc1, 16'h0);
    check_eq("clr_ovf1", ovf1, 1'b0);
    check_eq("clr_state1", st1, 2'd0);

    // Reset on the 3rd MUL edge of 0xFF*0xFF.
    sel = 1'b0; data_a = 8'hFF; data_b = 8'hFF; sgn = 1'b0; start = 1'b1;
    @(posedge clk);            // sampling edge
    @(posedge clk);            // MUL edge 1
    @(posedge clk);            // MUL edge 2
    @(negedge clk);
    check_eq("mid_busy", busy0, 1'b1);
    check_eq("mid_state", st0, 2'd1);
    reset = 1'b1;
    @(posedge clk);            // MUL edge 3, reset seen
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check_eq("abort_state", st0, 2'd0);
    check_eq("abort_busy", busy0, 1'b0);
    check_eq("abort_done", done0, 1'b0);
    check_eq("abort_acc", acc0, 24'h0);
    check_eq("abort_prod", prod0, 16'h0);
    check_eq("abort_ovf", ovf0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    // Fresh op after abort.
    do_op(1'b0, 8'h07, 8'h06, 1'b0, 1'b0, 3, 16'h002A, 24'h00002A, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
# mac_seq

Parametrised sequential multiply-accumulate unit for the MAC datapath. It multiplies two N-bit operands, signed or unsigned, using a radix-2 shift-and-add loop that exits early, and adds the product into an ACC_W-bit accumulator. A sticky overflow flag is kept. Operation is controlled by a start/done level handshake, and the block sits between the operand source and the result consumer.

## Interface
- N, 32, operand width (N ≥ 2)
- ACC_W, 2*N+8, accumulator width (ACC_W ≥ 2*N)
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  synchronous, active-high reset
- start  input  1  request; level, held high until done is seen
- acc_clr  input  1  clear accumulator and ovf; honoured only in IDLE
- sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- data_a  input  N  multiplicand; sampled with start
- data_b  input  N  multiplier; sampled with start
- busy  output  1  high in MUL and ADD
- done  output  1  high in DONE
- prod  output  2N  last product (signed or unsigned per sgn)
- acc  output  ACC_W  accumulator
- ovf  output  1  sticky accumulate overflow

## Operation
- FSM states: IDLE, MUL, ADD, DONE.
- IDLE:
  - If acc_clr=1: acc←0, ovf←0.
  - If start=1: latch sgn, neg = sgn & (a[N-1] ^ b[N-1]), ma = |a|, mb = |b|.
    - Magnitudes are taken only when sgn=1; -2^(N-1) maps to 2^(N-1) and fits in N bits unsigned.
    - pp←0, then go to MUL.
  - acc_clr and start together: the clear happens first, then the new product accumulates into 0.
- MUL, on each edge:
  - If mb[0]: pp←pp+ma. ma is 2N wide and zero-extended.
  - ma←ma<<1, mb←mb>>1.
  - If (mb>>1)==0, go to ADD.
- ADD:
  - p = neg ? -pp : pp, in 2N bits.
  - prod←p.
  - acc←acc+ext(p): sign-extend when sgn=1, zero-extend otherwise. Result wraps modulo 2^ACC_W.
  - ovf is set if sgn=0 and the add carries out of ACC_W.
  - ovf is set if sgn=1 and both addends have the same sign but the sum's sign differs.
  - ovf is never cleared by an add. Go to DONE.
- DONE:
  - Hold outputs while start=1.
  - Return to IDLE on start=0.
  - acc_clr is ignored.
- data_a, data_b and sgn are don't-care outside the sampling edge.

## Timing
- Reset values:
  - State IDLE.
  - busy=0, done=0, prod=0, acc=0, ovf=0.
  - Internal ma, mb, pp = 0.
- Reset has priority in every state. Asserting it mid-operation aborts the operation and clears acc/ovf on the same edge.
- k = number of MUL cycles = max(1, msb_index(mb)+1). For mb=0, k=1; for mb=0xFF at N=8, k=8.
- Latency: done rises k+2 edges after the edge that samples start in IDLE. prod and acc are valid from the same edge.
- busy covers exactly k+1 cycles.
- A start held high after done does not retrigger. A new operation needs start=0 for at least one IDLE edge.
- Throughput: one MAC per k+3 cycles minimum, including the IDLE cycle.

## Test plan
- N=8, ACC_W=24, sgn=0, acc_clr+start with a=0xFF, b=0xFF:
  - k=8; done after 10 edges.
  - prod=0xFE01, acc=0x00FE01, ovf=0.
- sgn=1, acc cleared, a=0x80 (-128), b=0x80:
  - prod=0x4000, acc=0x004000.
  - Then a=0xFD (-3), b=0x05: k=3, prod=0xFFF1, acc=0x003FF1.
- sgn=1 from clear, a=0x05, b=0x00:
  - k=1; done after 3 edges; prod=0, acc=0.
  - Then a=0x01, b=0xFF (-1): prod=0xFFFF, acc=0xFFFFFF, ovf=0.
- Instance with ACC_W=16, sgn=0, a=b=0xFF twice:
  - After the first op: acc=0xFE01, ovf=0.
  - After the second: acc=0xFC02, ovf=1.
  - ovf stays 1 through a third op.
  - acc_clr in IDLE gives acc=0, ovf=0.
- Handshake: hold start high 5 cycles past done.
  - No second accumulate; done stays 1.
  - Drop start: IDLE next edge, done=0.
- Reset mid-MUL: assert reset at the 3rd MUL edge of 0xFF×0xFF.
  - Next edge: IDLE, busy=0, done=0, acc=0, prod=0.
  - A fresh op then completes correctly.
